terminal_request_tx: RTL and testbench

TERMINAL_REQUEST_TX -- requirements
Module: terminal_request_tx

---
 rtl/terminal_pkg.sv | 21 ++
 rtl/terminal_request_tx_if.sv | 38 +++
 rtl/sync_2ff.sv | 31 +++
 rtl/terminal_request_tx.sv | 158 +++++++++++++++
 tb/tb_terminal_request_tx.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/terminal_pkg.sv
// terminal_pkg
// Shared types and constants for the terminal request transmitter.
//   state_t : FSM state encoding (IDLE, DEBOUNCE, REQ, COOLDOWN)
//   HH_W    : width of the terminal switch word (3-bit auth code + function bit)
//   B_W     : width of the push-button word (active-low)
//   B_IDLE  : button value with nothing pressed
package terminal_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_REQ      = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  localparam int HH_W = 4;
  localparam int B_W  = 2;

  localparam logic [B_W-1:0] B_IDLE = 2'b11;

endpackage

// File: rtl/terminal_request_tx_if.sv
// terminal_request_tx_if
// Request handshake between the terminal transmitter and the access-control
// decoder.
//   req_valid   : request presented (driven by master)
//   req_hh      : captured switch payload (driven by master)
//   req_b       : captured button payload, active-low (driven by master)
//   busy        : transmitter not idle (driven by master)
//   timeout_err : one-cycle pulse when the decoder never answered (master)
//   ack         : decoder accepts the presented request (driven by slave)
interface terminal_request_tx_if;
  import terminal_pkg::*;

  logic            req_valid;
  logic [HH_W-1:0] req_hh;
  logic [B_W-1:0]  req_b;
  logic            busy;
  logic            timeout_err;
  logic            ack;

  modport master (
    output req_valid,
    output req_hh,
    output req_b,
    output busy,
    output timeout_err,
    input  ack
  );

  modport slave (
    input  req_valid,
    input  req_hh,
    input  req_b,
    input  busy,
    input  timeout_err,
    output ack
  );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a bus of quasi-static asynchronous inputs.
// Each bit is synchronized independently; callers must only feed it
// signals whose bit-to-bit skew is tolerable (switches, buttons).
//   clk : destination clock
//   rst : synchronous active-high reset, loads RESET_VAL into both flops
//   d   : asynchronous input
//   q   : synchronized output, two clk edges behind d
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/terminal_request_tx.sv
// terminal_request_tx
// Turns a debounced push-button press on a terminal into a single request
// carrying the switch and button state, waits for the decoder to accept it
// (or times out), then cools down until the button is released.
//   clk   : single clock, rising edge
//   rst   : synchronous active-high reset
//   HH    : raw switches, [3:1] auth code, [0] function bit (asynchronous)
//   B     : raw active-low buttons, idle 2'b11 (asynchronous)
//   bus   : master side of the request handshake (req_valid/req_hh/req_b,
//           busy, timeout_err out; ack in)
module terminal_request_tx
  import terminal_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACK_TIMEOUT     = 255,
  parameter int COOLDOWN_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [HH_W-1:0]        HH,
  input  logic [B_W-1:0]         B,
  terminal_request_tx_if.master  bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  localparam int CW = $clog2(COOLDOWN_CYCLES) + 1;

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] CD_LAST  = CW'(COOLDOWN_CYCLES - 1);

  logic [HH_W-1:0] hh_sync;
  logic [B_W-1:0]  b_sync;

  state_t          state, state_next;
  logic [DW-1:0]   deb_cnt, deb_cnt_next;
  logic [TW-1:0]   to_cnt, to_cnt_next;
  logic [CW-1:0]   cd_cnt, cd_cnt_next;
  logic [B_W-1:0]  cand, cand_next;
  logic [HH_W-1:0] req_hh_q, req_hh_next;
  logic [B_W-1:0]  req_b_q, req_b_next;
  logic            timeout_q, timeout_next;

  sync_2ff #(
    .WIDTH     (HH_W),
    .RESET_VAL ('0)
  ) u_sync_hh (
    .clk (clk),
    .rst (rst),
    .d   (HH),
    .q   (hh_sync)
  );

  sync_2ff #(
    .WIDTH     (B_W),
    .RESET_VAL (B_IDLE)
  ) u_sync_b (
    .clk (clk),
    .rst (rst),
    .d   (B),
    .q   (b_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      deb_cnt   <= '0;
      to_cnt    <= '0;
      cd_cnt    <= '0;
      cand      <= B_IDLE;
      req_hh_q  <= '0;
      req_b_q   <= B_IDLE;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      deb_cnt   <= deb_cnt_next;
      to_cnt    <= to_cnt_next;
      cd_cnt    <= cd_cnt_next;
      cand      <= cand_next;
      req_hh_q  <= req_hh_next;
      req_b_q   <= req_b_next;
      timeout_q <= timeout_next;
    end
  end

  // Each counter compares its current value against LAST before stepping,
  // so it never exceeds LAST and cannot wrap. The cooldown counter parks at
  // CD_LAST while the button is still held.
  always_comb begin
    state_next   = state;
    deb_cnt_next = deb_cnt;
    to_cnt_next  = to_cnt;
    cd_cnt_next  = cd_cnt;
    cand_next    = cand;
    req_hh_next  = req_hh_q;
    req_b_next   = req_b_q;
    timeout_next = 1'b0;

    case (state)
      ST_IDLE: begin
        if (b_sync != B_IDLE) begin
          cand_next    = b_sync;
          deb_cnt_next = '0;
          state_next   = ST_DEBOUNCE;
        end
      end

      ST_DEBOUNCE: begin
        if (b_sync != cand) begin
          state_next = ST_IDLE;
        end else if (deb_cnt == DEB_LAST) begin
          req_hh_next = hh_sync;
          req_b_next  = cand;
          to_cnt_next = '0;
          state_next  = ST_REQ;
        end else begin
          deb_cnt_next = deb_cnt + DW'(1);
        end
      end

      // ack is checked before the timeout so a late ack still wins
      ST_REQ: begin
        if (bus.ack) begin
          cd_cnt_next = '0;
          state_next  = ST_COOLDOWN;
        end else if (to_cnt == TO_LAST) begin
          timeout_next = 1'b1;
          cd_cnt_next  = '0;
          state_next   = ST_COOLDOWN;
        end else begin
          to_cnt_next = to_cnt + TW'(1);
        end
      end

      ST_COOLDOWN: begin
        if (cd_cnt == CD_LAST) begin
          if (b_sync == B_IDLE) begin
            state_next = ST_IDLE;
          end
        end else begin
          cd_cnt_next = cd_cnt + CW'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.req_valid   = (state == ST_REQ);
  assign bus.busy        = (state != ST_IDLE);
  assign bus.req_hh      = req_hh_q;
  assign bus.req_b       = req_b_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_terminal_request_tx.sv
// tb_terminal_request_tx
// Directed bench for terminal_request_tx with DEBOUNCE_CYCLES=4,
// ACK_TIMEOUT=8, COOLDOWN_CYCLES=4. "Edge N" is the Nth rising edge after
// a scenario's stimulus is applied; inputs change 1 time unit after an edge
// and outputs are read at that same point.
module tb_terminal_request_tx;
  import terminal_pkg::*;

  localparam int DC = 4;
  localparam int AT = 8;
  localparam int CD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] HH;
  logic [1:0] B;

  int compared   = 0;
  int mismatched = 0;
  int edge_n     = 0;
  int valid_rises = 0;
  int base_rises;
  int terr_count;

  terminal_request_tx_if bus();

  terminal_request_tx #(
    .DEBOUNCE_CYCLES (DC),
    .ACK_TIMEOUT     (AT),
    .COOLDOWN_CYCLES (CD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .HH  (HH),
    .B   (B),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Counts every rising edge of req_valid so scenarios can assert how many
  // requests were issued over a window.
  always @(posedge bus.req_valid) valid_rises++;

  task automatic check_output(input string tag, input logic [7:0] got,
                              input logic [7:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] hh, input logic [1:0] b);
    HH = hh;
    B  = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic step_to(input int n);
    while (edge_n < n) step();
  endtask

  initial begin
    rst     = 1'b1;
    HH      = 4'b0000;
    B       = 2'b11;
    bus.ack = 1'b0;
    step();
    step();
    check_output("rst_valid",   bus.req_valid,   8'd0);
    check_output("rst_busy",    bus.busy,        8'd0);
    check_output("rst_timeout", bus.timeout_err, 8'd0);
    check_output("rst_req_hh",  bus.req_hh,      8'h0);
    check_output("rst_req_b",   bus.req_b,       8'h3);
    rst = 1'b0;
    step();
    step();

    // Basic press, latency 3+DC, ack, release, cooldown exit
    edge_n = 0;
    apply_stimulus(4'b1011, 2'b10);
    step_to(6);
    check_output("s1_valid_e6", bus.req_valid, 8'd0);
    step_to(7);
    check_output("s1_valid_e7", bus.req_valid, 8'd1);
    check_output("s1_req_hh",   bus.req_hh,    8'hb);
    check_output("s1_req_b",    bus.req_b,     8'h2);
    check_output("s1_busy_e7",  bus.busy,      8'd1);
    step_to(9);
    check_output("s1_valid_e9", bus.req_valid, 8'd1);
    bus.ack = 1'b1;
    step_to(10);
    bus.ack = 1'b0;
    check_output("s1_valid_e10", bus.req_valid, 8'd0);
    check_output("s1_busy_e10",  bus.busy,      8'd1);
    apply_stimulus(4'b1011, 2'b11);
    step_to(13);
    check_output("s1_busy_e13", bus.busy, 8'd1);
    step_to(14);
    check_output("s1_busy_e14", bus.busy,   8'd0);
    check_output("s1_keep_hh",  bus.req_hh, 8'hb);
    check_output("s1_keep_b",   bus.req_b,  8'h2);

    // Short glitch never produces a request; stray ack in IDLE is ignored
    edge_n = 0;
    base_rises = valid_rises;
    apply_stimulus(4'b1111, 2'b10);
    step_to(3);
    apply_stimulus(4'b1111, 2'b11);
    step_to(5);
    check_output("s2_busy_e5", bus.busy, 8'd1);
    step_to(6);
    check_output("s2_busy_e6", bus.busy, 8'd0);
    bus.ack = 1'b1;
    step_to(12);
    bus.ack = 1'b0;
    check_output("s2_no_valid", 8'(valid_rises - base_rises), 8'd0);
    check_output("s2_busy_e12", bus.busy,   8'd0);
    check_output("s2_keep_hh",  bus.req_hh, 8'hb);
    check_output("s2_keep_b",   bus.req_b,  8'h2);

    // No ack: timeout pulse exactly once, AT edges after valid rises
    edge_n = 0;
    apply_stimulus(4'b0110, 2'b01);
    step_to(7);
    check_output("s3_valid_e7", bus.req_valid, 8'd1);
    check_output("s3_req_hh",   bus.req_hh,    8'h6);
    check_output("s3_req_b",    bus.req_b,     8'h1);
    terr_count = 0;
    while (edge_n < 20) begin
      step();
      if (bus.timeout_err) terr_count++;
      if (edge_n == 14) begin
        check_output("s3_valid_e14", bus.req_valid,   8'd1);
        check_output("s3_terr_e14",  bus.timeout_err, 8'd0);
      end
      if (edge_n == 15) begin
        check_output("s3_terr_e15",  bus.timeout_err, 8'd1);
        check_output("s3_valid_e15", bus.req_valid,   8'd0);
        apply_stimulus(4'b0110, 2'b11);
      end
    end
    check_output("s3_terr_pulses", 8'(terr_count), 8'd1);
    check_output("s3_busy_e20",    bus.busy,        8'd0);

    // ack in the final timeout cycle wins
    edge_n = 0;
    apply_stimulus(4'b1001, 2'b10);
    step_to(14);
    check_output("s4_valid_e14", bus.req_valid, 8'd1);
    bus.ack = 1'b1;
    step_to(15);
    bus.ack = 1'b0;
    check_output("s4_valid_e15", bus.req_valid,   8'd0);
    check_output("s4_terr_e15",  bus.timeout_err, 8'd0);
    apply_stimulus(4'b1001, 2'b11);
    step_to(16);
    check_output("s4_terr_e16", bus.timeout_err, 8'd0);
    step_to(20);
    check_output("s4_busy_e20", bus.busy, 8'd0);

    // Button held 50 cycles: one request only, cooldown held until release
    edge_n = 0;
    base_rises = valid_rises;
    apply_stimulus(4'b0011, 2'b10);
    step_to(7);
    check_output("s5_valid_e7", bus.req_valid, 8'd1);
    bus.ack = 1'b1;
    step_to(8);
    bus.ack = 1'b0;
    check_output("s5_valid_e8", bus.req_valid, 8'd0);
    step_to(50);
    check_output("s5_busy_e50", bus.busy, 8'd1);
    check_output("s5_one_req",  8'(valid_rises - base_rises), 8'd1);
    apply_stimulus(4'b0011, 2'b11);
    step_to(52);
    check_output("s5_busy_e52", bus.busy, 8'd1);
    step_to(53);
    check_output("s5_busy_e53", bus.busy, 8'd0);

    // Reset during REQ
    edge_n = 0;
    apply_stimulus(4'b1011, 2'b10);
    step_to(8);
    check_output("s6_valid_e8", bus.req_valid, 8'd1);
    rst = 1'b1;
    step_to(9);
    rst = 1'b0;
    check_output("s6_rst_valid", bus.req_valid,   8'd0);
    check_output("s6_rst_busy",  bus.busy,        8'd0);
    check_output("s6_rst_req_b", bus.req_b,       8'h3);
    check_output("s6_rst_hh",    bus.req_hh,      8'h0);
    check_output("s6_rst_terr",  bus.timeout_err, 8'd0);

    // Next press behaves like the basic one; HH/B changes during REQ
    // do not disturb the captured payload
    edge_n = 0;
    step_to(6);
    check_output("s7_valid_e6", bus.req_valid, 8'd0);
    step_to(7);
    check_output("s7_valid_e7", bus.req_valid, 8'd1);
    check_output("s7_req_hh",   bus.req_hh,    8'hb);
    check_output("s7_req_b",    bus.req_b,     8'h2);
    apply_stimulus(4'b0100, 2'b01);
    step_to(9);
    check_output("s7_hold_hh",    bus.req_hh,    8'hb);
    check_output("s7_hold_b",     bus.req_b,     8'h2);
    check_output("s7_hold_valid", bus.req_valid, 8'd1);
    bus.ack = 1'b1;
    step_to(10);
    bus.ack = 1'b0;
    check_output("s7_valid_e10", bus.req_valid, 8'd0);
    apply_stimulus(4'b0100, 2'b11);
    step_to(16);
    check_output("s7_busy_e16", bus.busy,   8'd0);
    check_output("s7_keep_hh",  bus.req_hh, 8'hb);
    edge_n = 0;
    apply_stimulus(4'b0100, 2'b01);
    step_to(7);
    check_output("s7_new_valid", bus.req_valid, 8'd1);
    check_output("s7_new_hh",    bus.req_hh,    8'h4);
    check_output("s7_new_b",     bus.req_b,     8'h1);
    bus.ack = 1'b1;
    step_to(8);
    bus.ack = 1'b0;
    apply_stimulus(4'b0100, 2'b11);
    step_to(14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
